// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the memory-path self-test master.
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_GAP,
    RD_REQ,
    RD_GAP,
    FINISH
  } state_t;

  localparam logic [3:0] WSTRB_ALL = 4'hF;

  // Each word carries its own index in the high half, so address aliasing shows up as a mismatch.
  function automatic logic [31:0] pat(input logic [15:0] idx, input logic [31:0] seed);
    return {idx, ~idx} ^ seed;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_test_checker.sv
// Read-back comparison: saturating mismatch counter and first-mismatch address capture.
module mem_test_checker
  import mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        check,
  input  logic [31:0] rdata,
  input  logic [31:0] expected,
  input  logic [31:0] addr,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);

  logic mismatch;

  assign mismatch = check && (rdata != expected);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      err_count <= sat_inc(err_count);
      if (err_count == 16'd0) first_err_addr <= addr;
    end
  end

endmodule

// File: rtl/mem_test_master.sv
// Self-test initiator on the picorv32 native memory bus: write a seeded pattern, read it back.
// Optional per-transaction timeout enabled by defining MEM_TEST_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// WR_REQ | write request for word idx outstanding
// WR_GAP | one idle bus cycle after a write; advance idx
// RD_REQ | read request for word idx outstanding
// RD_GAP | one idle bus cycle after a read; advance idx
// FINISH | results valid; start re-arms
module mem_test_master
  import mem_test_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          WORDS      = 16,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nxt;
  logic [15:0] idx;
  logic [31:0] seed_q;
  logic [31:0] word_addr;
  logic [31:0] word_pat;
  logic        start_acc;
  logic        last_word;
  logic        in_gap;
  logic        timeout_hit;

  assign start_acc = start && (state == IDLE || state == FINISH);
  assign last_word = (idx == 16'(WORDS - 1));
  assign in_gap    = (state == WR_GAP) || (state == RD_GAP);
  assign word_addr = START_ADDR + {14'd0, idx, 2'b00};
  assign word_pat  = pat(idx, seed_q);

  assign mem_valid = (state == WR_REQ) || (state == RD_REQ);
  assign mem_instr = 1'b0;
  assign mem_addr  = mem_valid ? word_addr : '0;
  assign mem_wdata = (state == WR_REQ) ? word_pat : '0;
  assign mem_wstrb = (state == WR_REQ) ? WSTRB_ALL : 4'h0;
  assign busy      = mem_valid || in_gap;
  assign done      = (state == FINISH);
  assign pass      = done && (err_count == 16'd0) && !timeout_err;

`ifdef MEM_TEST_MASTER_TIMEOUT_EN
  logic [31:0] tmr;
  logic        timeout_q;

  // Reloaded whenever the bus is idle, so every request starts with a full budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!mem_valid)      tmr <= 32'(TIMEOUT - 1);
      else if (!mem_ready) tmr <= tmr - 32'd1;
      if (start_acc)        timeout_q <= 1'b0;
      else if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_hit = mem_valid && !mem_ready && (tmr == '0);
  assign timeout_err = timeout_q;
`else
  // Without the timer the master waits on mem_ready forever.
  assign timeout_hit = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      seed_q <= '0;
    end else if (start_acc) begin
      idx    <= '0;
      seed_q <= seed;
    end else if (in_gap) begin
      idx <= last_word ? 16'd0 : idx + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: if (start) state_nxt = WR_REQ;
      WR_REQ: begin
        if (mem_ready)        state_nxt = WR_GAP;
        else if (timeout_hit) state_nxt = FINISH;
      end
      WR_GAP: state_nxt = last_word ? RD_REQ : WR_REQ;
      RD_REQ: begin
        if (mem_ready)        state_nxt = RD_GAP;
        else if (timeout_hit) state_nxt = FINISH;
      end
      RD_GAP: state_nxt = last_word ? FINISH : RD_REQ;
      default: state_nxt = IDLE;
    endcase
  end

  mem_test_checker u_checker (
    .clk            (clk),
    .reset          (reset),
    .clear          (start_acc),
    .check          ((state == RD_REQ) && mem_ready),
    .rdata          (mem_rdata),
    .expected       (word_pat),
    .addr           (word_addr),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_mem_test_master.sv
// Scoreboard bench: expected bus transactions and run results are queued at stimulus time and checked by monitors.
`timescale 1ns/1ps
module tb_mem_test_master;
  import mem_test_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0C00;
  localparam int          NW   = 4;
  localparam int          TMO  = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    logic [15:0] err;
    logic [31:0] fea;
    logic        pass_v;
    logic        tmo;
    int          cycles;
  } res_t;

  logic        clk, reset, start;
  logic [31:0] seed;
  logic        busy, done, pass, timeout_err, mem_valid, mem_instr, mem_ready;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        b_start, b_busy, b_done, b_pass, b_tmo, b_valid, b_instr, b_ready;
  logic [31:0] b_seed, b_fea, b_addr, b_wdata, b_rdata, b_store;
  logic [15:0] b_err;
  logic [3:0]  b_wstrb;
  int          b_hs;

  txn_t exp_q[$];
  res_t res_q[$];
  res_t r_mon;
  txn_t t_mon;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st_cyc = 0;

  logic [31:0] mem [NW];
  int  fix_lat = 1, cur_lat = 1, wcnt = 0;
  bit  rand_lat = 0, corrupt = 0, never_ready = 0;
  logic        prev_valid = 0, prev_ready = 0, done_d = 0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;
  logic [3:0]  prev_wstrb = 0;

  mem_test_master #(.START_ADDR(BASE), .WORDS(NW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .timeout_err(timeout_err),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  mem_test_master #(.START_ADDR(32'hFFFF_FFFC), .WORDS(1), .TIMEOUT(TMO)) dut_one (
    .clk(clk), .reset(reset), .start(b_start), .seed(b_seed),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout_err(b_tmo),
    .err_count(b_err), .first_err_addr(b_fea),
    .mem_valid(b_valid), .mem_instr(b_instr), .mem_ready(b_ready),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_rdata(b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Responder with ready latency L and a transaction scoreboard.
  always @(negedge clk) begin
    if (mem_valid && prev_valid && !prev_ready) begin
      chk("stable_addr", mem_addr, prev_addr);
      chk("stable_wdata", mem_wdata, prev_wdata);
      chk("stable_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
    end
    if (prev_ready && !reset) chk("gap_after_handshake", 32'(mem_valid), 0);
    if (reset) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_valid && !never_ready) begin
      if (wcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 5)) : fix_lat;
      if (wcnt == cur_lat - 1) begin
        if (exp_q.size() == 0) begin
          chk("txn_expected", 32'(exp_q.size()), 1);
        end else begin
          t_mon = exp_q.pop_front();
          chk("txn_addr", mem_addr, t_mon.addr);
          chk("txn_wstrb", 32'(mem_wstrb), 32'(t_mon.wstrb));
          if (t_mon.wstrb == 4'hF) begin
            chk("txn_wdata", mem_wdata, t_mon.wdata);
            mem[mem_addr[3:2]] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[3:2]] ^
                        ((corrupt && mem_addr == BASE + 32'h8) ? 32'h1 : 32'h0);
          end
        end
        mem_ready = 1'b1;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
    prev_valid = mem_valid;
    prev_ready = mem_ready;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_wstrb = mem_wstrb;
  end

  // Result monitor: compares counters when done rises.
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (res_q.size() == 0) begin
        chk("result_expected", 32'(res_q.size()), 1);
      end else begin
        r_mon = res_q.pop_front();
        chk("err_count", 32'(err_count), 32'(r_mon.err));
        chk("first_err_addr", first_err_addr, r_mon.fea);
        chk("pass", 32'(pass), 32'(r_mon.pass_v));
        chk("timeout_err", 32'(timeout_err), 32'(r_mon.tmo));
        if (r_mon.cycles > 0) chk("run_cycles", 32'(cyc - st_cyc), 32'(r_mon.cycles));
      end
    end
    done_d = done;
  end

  // Single-word responder at the top of the address space, latency 1.
  always @(negedge clk) begin
    if (reset) begin
      b_ready = 1'b0;
    end else if (b_valid && !b_ready) begin
      b_hs++;
      chk("one_word_addr", b_addr, 32'hFFFF_FFFC);
      if (b_wstrb == 4'hF) begin
        chk("one_word_wdata", b_wdata, 32'h1234_A987);
        b_store = b_wdata;
      end
      b_rdata = b_store;
      b_ready = 1'b1;
    end else begin
      b_ready = 1'b0;
    end
  end

  task automatic push_txns(input logic [31:0] s);
    logic [31:0] base_pat [NW];
    base_pat[0] = 32'h0000_FFFF;
    base_pat[1] = 32'h0001_FFFE;
    base_pat[2] = 32'h0002_FFFD;
    base_pat[3] = 32'h0003_FFFC;
    for (int i = 0; i < NW; i++) exp_q.push_back('{BASE + 32'(4 * i), base_pat[i] ^ s, 4'hF});
    for (int i = 0; i < NW; i++) exp_q.push_back('{BASE + 32'(4 * i), 32'h0, 4'h0});
  endtask

  task automatic do_start(input logic [31:0] s);
    logic was_done;
    @(negedge clk);
    was_done = done;
    seed = s;
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (was_done) chk("restart_clears_done", 32'(done), 0);
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_results(input int budget);
    int n = 0;
    while (res_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_within_budget", 32'(res_q.size()), 0);
    res_q.delete();
  endtask

  task automatic run(input logic [31:0] s, input int lat, input bit rnd, input bit corr,
                     input logic [15:0] e_err, input logic [31:0] e_fea, input logic e_pass,
                     input int e_cyc, input int poke);
    fix_lat  = lat;
    rand_lat = rnd;
    corrupt  = corr;
    push_txns(s);
    res_q.push_back('{e_err, e_fea, e_pass, 1'b0, e_cyc});
    do_start(s);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      seed  = 32'hFFFF_FFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_during_ignored_start", 32'(busy), 1);
    end
    wait_results(2000);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    corrupt  = 1'b0;
    rand_lat = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; seed = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    b_start = 1'b0; b_seed = '0; b_ready = 1'b0; b_rdata = '0; b_store = '0; b_hs = 0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_first_err_addr", first_err_addr, 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_instr", 32'(mem_instr), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    reset = 1'b0;

    chk("sat_inc_0", 32'(sat_inc(16'h0000)), 32'h1);
    chk("sat_inc_fffe", 32'(sat_inc(16'hFFFE)), 32'hFFFF);
    chk("sat_inc_ffff", 32'(sat_inc(16'hFFFF)), 32'hFFFF);

    // zero-error, L=1: 2*4*2+1 = 17 cycles
    run(32'h0, 1, 0, 0, 16'd0, 32'h0, 1'b1, 17, 0);
    // seeded run with bit 0 flipped on the read of 0x0C08
    run(32'hA5A5_A5A5, 1, 0, 1, 16'd1, 32'h0000_0C08, 1'b0, 17, 0);
    // L=2 with a start pulse mid-run that must be ignored: 2*4*3+1 = 25
    run(32'h0F0F_1234, 2, 0, 0, 16'd0, 32'h0, 1'b1, 25, 6);
    // random wait states 1..5
    run(32'h5A5A_5A5A, 1, 1, 0, 16'd0, 32'h0, 1'b1, 0, 0);

    never_ready = 1'b1;
`ifdef MEM_TEST_MASTER_TIMEOUT_EN
    res_q.push_back('{16'd0, 32'h0, 1'b0, 1'b1, 0});
    do_start(32'h0);
    n = 0;
    while (mem_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_valid_cycles", 32'(n), 32'(TMO));
    wait_results(50);
    chk("timeout_done_level", 32'(done), 1);
`else
    do_start(32'h0);
    repeat (30) @(negedge clk);
    chk("no_timeout_valid_held", 32'(mem_valid), 1);
    chk("no_timeout_not_done", 32'(done), 0);
    chk("no_timeout_err_low", 32'(timeout_err), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    never_ready = 1'b0;
    exp_q.delete();

    // reset in the middle of the read of word 2
    fix_lat = 3;
    push_txns(32'h0);
    do_start(32'h0);
    n = 0;
    while (!(mem_valid && mem_wstrb == 4'h0 && mem_addr == BASE + 32'h8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_read_word2", 32'(n < 200), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", 32'(mem_valid), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    reset = 1'b0;
    exp_q.delete();
    res_q.delete();
    run(32'h0, 1, 0, 0, 16'd0, 32'h0, 1'b1, 17, 0);

    // one word at the top of the address space: 2*1*2+1 = 5 cycles
    @(negedge clk);
    b_seed = 32'h1234_5678;
    b_start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("one_word_run_cycles", 32'(cyc - st_cyc), 32'd5);
    chk("one_word_handshakes", 32'(b_hs), 32'd2);
    chk("one_word_pass", 32'(b_pass), 1);
    chk("one_word_err_count", 32'(b_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
